lc3_mem_dump: RTL and testbench
===============================

Name: lc3_mem_dump

Overview:
- Hardware read-back engine for LC-3 main memory, the counterpart of the program loader.
- Reads a contiguous range of 16-bit words from the memory read port and streams them out over a valid/ready interface.
- The stream uses the load-file format: first word is the start address, then one word per location.
- Used by the host/debug path to dump program and data regions after or during a run.

Parameters:
- WORD_W, 16, width of a memory word and of an address.
- MEM_LAT, 1, memory read latency in cycles; only the value 1 is supported.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- start_addr  in  16  first memory address to read; sampled with start.
- count  in  16  number of data words to read; sampled with start. 0 means header only.
- abort  in  1  synchronous cancel.
- busy  out  1  high from the cycle after start is accepted until return to IDLE.
- done  out  1  one-cycle pulse after the final handshake.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  16  memory read address.
- mem_rd_data  in  16  read data, valid exactly one cycle after mem_rd_en.
- out_valid  out  1  stream word valid.
- out_ready  in  1  downstream accept.
- out_data  out  16  stream word (header or data).
- out_addr  out  16  address of the data word; equals start_addr during the header.
- out_last  out  1  marks the final word of the stream.

Behaviour:
- Reset (async, rst=1): state=IDLE. busy, done, mem_rd_en, out_valid, out_last = 0. mem_addr, out_data, out_addr, internal address and remaining count = 0.
- All outputs are registered, except mem_rd_en and mem_addr, which decode from state and the address register.
- Handshake: a word transfers on a cycle with out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_data, out_addr and out_last hold stable.
  - out_valid never drops without a transfer, except on abort or reset.
- States:
  - IDLE: start=1 latches addr<=start_addr and rem<=count, loads the header (out_data=start_addr, out_addr=start_addr, out_last=(count==0)), then goes to HDR. out_valid=1 in the next cycle.
  - HDR: on handshake, go to DONE if count==0, else to READ.
  - READ: mem_rd_en=1, mem_addr=addr for exactly one cycle, then go to CAPT.
  - CAPT: out_data<=mem_rd_data, out_addr<=addr, out_last<=(rem==1), out_valid<=1. Then addr<=addr+1 (mod 2^16) and rem<=rem-1. Go to SEND.
  - SEND: on handshake, go to DONE if out_last, else to READ.
  - DONE: done=1 for one cycle, busy=0, out_valid=0, then go to IDLE.
- Throughput: a data word is presented 2 cycles after leaving HDR/SEND with out_ready held high, i.e. 3 cycles per word.
- Address wrap: after reading 0xFFFF the next read is 0x0000; no error is flagged.
- count is 16-bit, so 65535 is the maximum number of data words.
- start while busy is ignored; there is no queuing.
- abort=1 in any non-IDLE state: next state is IDLE, out_valid=0, busy=0, no done pulse.
  - A read issued in READ is discarded.
  - abort in IDLE is ignored.
  - abort and start together in IDLE: start wins.
- Reset mid-operation: immediate return to reset values; a partial stream is not resumed.
- Memory side effects: mem_rd_en is never asserted outside READ; there is no write port.

Decomposition:
- Shared package lc3_pkg:
  - word_t and addr_t (logic [15:0]).
  - dump_state_t enum {IDLE, HDR, READ, CAPT, SEND, DONE}.
  - Constant LC3_MEM_WORDS = 65536.
- No sub-module; the output register and FSM are small enough to live in one module.

Test Plan:
1. Memory x3000..x3002 = x1234, xABCD, x0000; start_addr=x3000, count=3, out_ready=1 -> stream x3000, x1234, xABCD, x0000. out_addr = x3000, x3000, x3001, x3002. out_last only on x0000. done pulses 1 cycle after the last handshake.
2. count=0, start_addr=x0200 -> single word x0200 with out_last=1; mem_rd_en never asserted; done pulses.
3. Wrap case: start_addr=xFFFE, count=3, mem[xFFFE]=x1111, mem[xFFFF]=x2222, mem[x0000]=x3333 -> data x1111, x2222, x3333 with out_addr xFFFE, xFFFF, x0000.
4. Backpressure: out_ready toggles 0,0,1 per word -> each word held stable while stalled; no duplicates or drops; total sequence identical to scenario 1.
5. abort asserted in SEND after the second data word is presented (no handshake) -> next cycle out_valid=0, busy=0, no done. A new start with count=1 then produces a correct 2-word stream.
6. Async reset asserted mid-CAPT between clock edges -> all outputs 0 immediately; start during busy (second pulse) produces no extra stream.

Source files
------------

// File: rtl/lc3_pkg.sv
// lc3_pkg: shared LC-3 word/address types, dump FSM states and memory size
package lc3_pkg;
  typedef logic [15:0] word_t;
  typedef logic [15:0] addr_t;
  typedef enum logic [2:0] {IDLE, HDR, READ, CAPT, SEND, DONE} dump_state_t;
  localparam int LC3_MEM_WORDS = 65536;
endpackage

// File: rtl/lc3_mem_dump.sv
// lc3_mem_dump: streams start address then count memory words over valid/ready (ports: start/abort control, mem read port, out stream, busy/done)
module lc3_mem_dump
  import lc3_pkg::*;
#(
  parameter int WORD_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] start_addr,
  input  logic [WORD_W-1:0] count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [WORD_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [WORD_W-1:0] out_addr,
  output logic              out_last
);
  dump_state_t       state, state_n;
  logic [WORD_W-1:0] addr, rem;
  logic              hs;
  if (MEM_LAT != 1) begin : g_lat
    $error("lc3_mem_dump supports MEM_LAT=1 only");
  end
  assign hs        = out_valid && out_ready;
  assign mem_rd_en = state == READ;
  assign mem_addr  = mem_rd_en ? addr : '0;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? HDR : IDLE;
      HDR:     state_n = hs ? (rem == '0 ? DONE : READ) : HDR;
      READ:    state_n = CAPT;
      CAPT:    state_n = SEND;
      SEND:    state_n = hs ? (out_last ? DONE : READ) : SEND;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort && state != IDLE) state_n = IDLE;
  end
  // status outputs are registered from the next state so they line up with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      addr      <= '0;
      rem       <= '0;
    end else begin
      state     <= state_n;
      busy      <= state_n inside {HDR, READ, CAPT, SEND};
      done      <= state_n == DONE;
      out_valid <= state_n inside {HDR, SEND};
      if (state == IDLE && start) begin
        addr     <= start_addr;
        rem      <= count;
        out_data <= start_addr;
        out_addr <= start_addr;
        out_last <= count == '0;
      end
      if (state == CAPT) begin
        out_data <= mem_rd_data;
        out_addr <= addr;
        out_last <= rem == WORD_W'(1);
        addr     <= addr + WORD_W'(1);
        rem      <= rem - WORD_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_lc3_mem_dump.sv
// tb_lc3_mem_dump: randomized self-checking bench against a load-file stream model
module tb_lc3_mem_dump;
  logic        clk = 1'b0;
  logic        rst, start, abort, out_ready;
  logic [15:0] start_addr, count, mem_rd_data;
  logic        busy, done, mem_rd_en, out_valid, out_last;
  logic [15:0] mem_addr, out_data, out_addr;
  logic [15:0] mem [0:65535];
  logic [15:0] got_d[$], got_a[$], exp_d[$], exp_a[$];
  logic        got_l[$], exp_l[$];
  int          checks = 0, passed = 0;
  int          n_rd, n_done, hs_cyc, done_cyc, unstable, extra_v;
  lc3_mem_dump dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .count(count),
    .abort(abort), .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .out_last(out_last)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  function automatic void build_exp(input logic [15:0] sa, input logic [15:0] cnt);
    exp_d.delete(); exp_a.delete(); exp_l.delete();
    exp_d.push_back(sa); exp_a.push_back(sa); exp_l.push_back(cnt == 0);
    for (int i = 0; i < int'(cnt); i++) begin
      logic [15:0] a;
      a = sa + 16'(i);
      exp_d.push_back(mem[a]); exp_a.push_back(a); exp_l.push_back(i == int'(cnt) - 1);
    end
  endfunction
  // mode 0: ready always high, 1: ready 0,0,1 per word, 2: random ready
  task automatic run(input logic [15:0] sa, input logic [15:0] cnt, input int mode, input int restart_at);
    logic [15:0] hd, ha;
    logic        hl, prev_stall, fin;
    int          stall;
    got_d.delete(); got_a.delete(); got_l.delete();
    n_rd = 0; n_done = 0; hs_cyc = -1; done_cyc = -1; unstable = 0; extra_v = 0;
    stall = 0; prev_stall = 0; fin = 0; hd = 0; ha = 0; hl = 0;
    @(negedge clk);
    start_addr = sa; count = cnt; start = 1'b1;
    @(negedge clk);
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      if (cyc == restart_at) begin
        start = 1'b1; start_addr = ~sa; count = 16'd7;
      end else start = 1'b0;
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? (stall == 2) : 1'($urandom_range(0, 1));
      if (mem_rd_en) n_rd++;
      if (done) begin n_done++; done_cyc = cyc; fin = 1'b1; end
      if (prev_stall && (!out_valid || out_data !== hd || out_addr !== ha || out_last !== hl)) unstable++;
      if (out_valid && out_ready) begin
        got_d.push_back(out_data); got_a.push_back(out_addr); got_l.push_back(out_last);
        hs_cyc = cyc; stall = 0;
      end else if (out_valid) stall++;
      prev_stall = out_valid && !out_ready;
      hd = out_data; ha = out_addr; hl = out_last;
      @(negedge clk);
    end
    start = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (done) n_done++;
      if (out_valid) extra_v++;
      if (mem_rd_en) n_rd++;
      @(negedge clk);
    end
  endtask
  task automatic test_reset;
    rst = 1'b1; start = 0; abort = 0; out_ready = 1; start_addr = 0; count = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, mem_rd_en, out_valid, out_last} !== 5'b0 || mem_addr !== 0 || out_data !== 0 || out_addr !== 0)
      $display("FAIL reset_outputs got ctl=%b mem_addr=%h data=%h addr=%h exp all zero",
               {busy, done, mem_rd_en, out_valid, out_last}, mem_addr, out_data, out_addr);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_basic;
    mem[16'h3000] = 16'h1234; mem[16'h3001] = 16'hABCD; mem[16'h3002] = 16'h0000;
    build_exp(16'h3000, 16'd3);
    run(16'h3000, 16'd3, 0, -1);
    checks++;
    if (got_d.size() != exp_d.size()) $display("FAIL basic_len got %0d exp %0d", got_d.size(), exp_d.size());
    else passed++;
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_a[i] !== exp_a[i] || got_l[i] !== exp_l[i])
        $display("FAIL basic_word%0d got %h/%h/%b exp %h/%h/%b", i, got_d[i], got_a[i], got_l[i], exp_d[i], exp_a[i], exp_l[i]);
      else passed++;
    end
    checks++;
    if (n_done != 1 || done_cyc - hs_cyc != 1)
      $display("FAIL basic_done got pulses=%0d delay=%0d exp 1/1", n_done, done_cyc - hs_cyc);
    else passed++;
    checks++;
    if (n_rd != 3) $display("FAIL basic_reads got %0d exp 3", n_rd);
    else passed++;
  endtask
  task automatic test_header_only;
    build_exp(16'h0200, 16'd0);
    run(16'h0200, 16'd0, 0, -1);
    checks++;
    if (got_d.size() != 1 || got_d[0] !== 16'h0200 || got_a[0] !== 16'h0200 || got_l[0] !== 1'b1)
      $display("FAIL header_only got n=%0d first=%h exp n=1 %h last=1", got_d.size(),
               got_d.size() > 0 ? got_d[0] : 16'hxxxx, exp_d[0]);
    else passed++;
    checks++;
    if (n_rd != 0) $display("FAIL header_only_reads got %0d exp 0", n_rd);
    else passed++;
    checks++;
    if (n_done != 1 || done_cyc - hs_cyc != 1)
      $display("FAIL header_only_done got pulses=%0d delay=%0d exp 1/1", n_done, done_cyc - hs_cyc);
    else passed++;
  endtask
  task automatic test_wrap;
    mem[16'hFFFE] = 16'h1111; mem[16'hFFFF] = 16'h2222; mem[16'h0000] = 16'h3333;
    build_exp(16'hFFFE, 16'd3);
    run(16'hFFFE, 16'd3, 0, -1);
    checks++;
    if (got_d.size() != exp_d.size()) $display("FAIL wrap_len got %0d exp %0d", got_d.size(), exp_d.size());
    else passed++;
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_a[i] !== exp_a[i] || got_l[i] !== exp_l[i])
        $display("FAIL wrap_word%0d got %h/%h/%b exp %h/%h/%b", i, got_d[i], got_a[i], got_l[i], exp_d[i], exp_a[i], exp_l[i]);
      else passed++;
    end
  endtask
  task automatic test_backpressure;
    build_exp(16'h3000, 16'd3);
    run(16'h3000, 16'd3, 1, -1);
    checks++;
    if (got_d.size() != exp_d.size()) $display("FAIL bp_len got %0d exp %0d", got_d.size(), exp_d.size());
    else passed++;
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_a[i] !== exp_a[i] || got_l[i] !== exp_l[i])
        $display("FAIL bp_word%0d got %h/%h/%b exp %h/%h/%b", i, got_d[i], got_a[i], got_l[i], exp_d[i], exp_a[i], exp_l[i]);
      else passed++;
    end
    checks++;
    if (unstable != 0) $display("FAIL bp_stable got %0d changes exp 0", unstable);
    else passed++;
    checks++;
    if (n_done != 1) $display("FAIL bp_done got %0d exp 1", n_done);
    else passed++;
  endtask
  task automatic test_abort;
    logic [15:0] sa;
    int          hs_n, seen, post_done;
    sa = 16'($urandom);
    for (int i = 0; i < 3; i++) mem[sa + 16'(i)] = 16'($urandom);
    hs_n = 0; seen = 0; post_done = 0;
    @(negedge clk);
    start_addr = sa; count = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
      out_ready = hs_n < 2;
      if (out_valid && out_ready) hs_n++;
      else if (hs_n == 2 && out_valid) begin
        seen = 1;
        checks++;
        if (out_data !== mem[sa + 16'd1] || out_addr !== sa + 16'd1)
          $display("FAIL abort_word got %h@%h exp %h@%h", out_data, out_addr, mem[sa + 16'd1], sa + 16'd1);
        else passed++;
        abort = 1'b1;
      end
      @(negedge clk);
    end
    abort = 1'b0;
    checks++;
    if (!seen || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL abort_stop got seen=%0d valid=%b busy=%b done=%b exp 1/0/0/0", seen, out_valid, busy, done);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      if (done || out_valid) post_done++;
      @(negedge clk);
    end
    checks++;
    if (post_done != 0) $display("FAIL abort_quiet got %0d active cycles exp 0", post_done);
    else passed++;
    sa = 16'($urandom);
    mem[sa] = 16'($urandom);
    build_exp(sa, 16'd1);
    run(sa, 16'd1, 0, -1);
    checks++;
    if (got_d.size() != 2 || got_d[0] !== exp_d[0] || got_d[1] !== exp_d[1] || got_a[1] !== exp_a[1] || got_l[1] !== 1'b1 || got_l[0] !== 1'b0)
      $display("FAIL abort_restart got n=%0d exp 2 words %h,%h", got_d.size(), exp_d[0], exp_d[1]);
    else passed++;
  endtask
  task automatic test_async_reset;
    int seen, active;
    seen = 0; active = 0;
    out_ready = 1'b1;
    @(negedge clk);
    start_addr = 16'h4000; count = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
      if (mem_rd_en) seen = 1;
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (!seen || {busy, done, mem_rd_en, out_valid, out_last} !== 5'b0 || mem_addr !== 0 || out_data !== 0 || out_addr !== 0)
      $display("FAIL async_reset got seen=%0d ctl=%b data=%h addr=%h exp 1/zeros", seen,
               {busy, done, mem_rd_en, out_valid, out_last}, out_data, out_addr);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid || busy || done) active++;
      @(negedge clk);
    end
    checks++;
    if (active != 0) $display("FAIL reset_no_resume got %0d active cycles exp 0", active);
    else passed++;
    mem[16'h5000] = 16'hBEEF; mem[16'h5001] = 16'hCAFE;
    build_exp(16'h5000, 16'd2);
    run(16'h5000, 16'd2, 0, 3);
    checks++;
    if (got_d.size() != 3 || got_d[1] !== 16'hBEEF || got_d[2] !== 16'hCAFE || got_l[2] !== 1'b1)
      $display("FAIL busy_start_stream got n=%0d exp 3 words", got_d.size());
    else passed++;
    checks++;
    if (extra_v != 0 || n_done != 1) $display("FAIL busy_start_ignored got extra=%0d done=%0d exp 0/1", extra_v, n_done);
    else passed++;
  endtask
  task automatic test_random;
    for (int t = 0; t < 4; t++) begin
      logic [15:0] sa, cnt;
      sa = 16'($urandom);
      cnt = 16'($urandom_range(1, 6));
      for (int i = 0; i < int'(cnt); i++) mem[sa + 16'(i)] = 16'($urandom);
      build_exp(sa, cnt);
      run(sa, cnt, 2, -1);
      checks++;
      if (got_d.size() != exp_d.size()) $display("FAIL rand%0d_len got %0d exp %0d", t, got_d.size(), exp_d.size());
      else passed++;
      for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
        checks++;
        if (got_d[i] !== exp_d[i] || got_a[i] !== exp_a[i] || got_l[i] !== exp_l[i])
          $display("FAIL rand%0d_word%0d got %h/%h/%b exp %h/%h/%b", t, i, got_d[i], got_a[i], got_l[i], exp_d[i], exp_a[i], exp_l[i]);
        else passed++;
      end
      checks++;
      if (unstable != 0 || n_done != 1) $display("FAIL rand%0d_proto got unstable=%0d done=%0d exp 0/1", t, unstable, n_done);
      else passed++;
    end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_header_only;
    test_wrap;
    test_backpressure;
    test_abort;
    test_async_reset;
    test_random;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
